// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN streaming blocks.
//   pixel_t      : one default-width pixel
//   pool_state_e : row phase of the 2x2 max-pool stage
//   ceil_div     : integer ceiling division
//   cnt_width    : counter width able to hold 0..n-1 (never zero bits)
package cnn_pkg;

   localparam int PIXEL_WIDTH = 8;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   typedef enum logic [1:0] {
      S_EVEN = 2'd0,
      S_ODD  = 2'd1,
      S_DROP = 2'd2
   } pool_state_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // A counter for a range of one still needs a single bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the horizontally reduced even row.
//   clk     : clock
//   wr_en   : write the entry at addr
//   addr    : beat index, shared by the write and read ports
//   wr_data : reduced even-row beat
//   rd_data : asynchronous read of the entry at addr
// Contents are not reset; every entry is written in the even row before
// the odd row reads it.
module pool_line_buf #(
   parameter int DEPTH = 7,
   parameter int WIDTH = 32,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/max_pool_stream.sv
// 2x2 stride-2 max-pooling stage on a row-major pixel stream.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : LANES pixels, lane 0 (leftmost) in the LSBs
//   in_valid   : input beat valid
//   in_ready   : input beat accepted this cycle
//   out_data   : LANES/2 pooled pixels, lane 0 in the LSBs
//   out_valid  : pooled beat valid
//   out_ready  : downstream accepts the pooled beat
//   out_last   : final pooled beat of the frame
//   frame_done : one-cycle pulse after the final pooled beat is taken
//   state      : current row phase, for observation
//
// Handshake: a beat transfers on a clock edge where valid && ready. Once
// out_valid is high, out_data/out_last stay constant until out_ready.
// Even rows are reduced horizontally into the line buffer; odd rows are
// reduced and merged with the buffered row to form one pooled beat per
// input beat. A trailing unpaired row (odd H_IN) is consumed and dropped.
module max_pool_stream
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 8,
   parameter int W_IN       = 56,
   parameter int H_IN       = 56,
   parameter int C          = 64,
   parameter int SIGNED     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LANES*DATA_WIDTH-1:0]       in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [(LANES/2)*DATA_WIDTH-1:0]   out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              out_last,
   output logic                              frame_done,
   output pool_state_e                       state
);

   localparam int BEATS  = W_IN / LANES;
   localparam int HALF   = LANES / 2;
   localparam int OW     = HALF * DATA_WIDTH;
   localparam int BEAT_W = cnt_width(BEATS);
   localparam int ROW_W  = cnt_width(H_IN);
   localparam int CH_W   = cnt_width(C);
   // Odd row that closes the final pooled row of a channel.
   localparam int LAST_ODD_ROW = (H_IN / 2) * 2 - 1;
   localparam bit H_ODD = (H_IN % 2) == 1;

   function automatic logic gt(input logic [DATA_WIDTH-1:0] x,
                               input logic [DATA_WIDTH-1:0] y);
      if (SIGNED != 0) return $signed(x) > $signed(y);
      else             return x > y;
   endfunction

   pool_state_e state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic [CH_W-1:0]   ch_cnt;
   logic accept, beat_end, row_end, ch_end;
   logic buf_wr, odd_acc;
   logic [OW-1:0] h, buf_rd, pooled;

   assign accept   = in_valid && in_ready;
   assign beat_end = (beat_cnt == BEAT_W'(BEATS - 1));
   assign row_end  = (row_cnt == ROW_W'(H_IN - 1));
   assign ch_end   = (ch_cnt == CH_W'(C - 1));
   assign state    = state_q;

   // Position counters advance on accepted input beats only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         row_cnt  <= '0;
         ch_cnt   <= '0;
      end else if (accept) begin
         if (beat_end) begin
            beat_cnt <= '0;
            if (row_end) begin
               row_cnt <= '0;
               ch_cnt  <= ch_end ? '0 : ch_cnt + 1'b1;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_EVEN;
      else     state_q <= state_d;
   end

   // FSM: next state, changes only at the end of a row
   always_comb begin
      state_d = state_q;
      if (accept && beat_end) begin
         case (state_q)
            S_EVEN:  state_d = S_ODD;
            S_ODD:   state_d = (H_ODD && (row_cnt == ROW_W'(H_IN - 2))) ? S_DROP : S_EVEN;
            default: state_d = S_EVEN;
         endcase
      end
   end

   // FSM: outputs. Only the odd row can stall, and only while a pooled
   // beat is waiting that will not drain this cycle.
   always_comb begin
      in_ready = 1'b1;
      buf_wr   = 1'b0;
      odd_acc  = 1'b0;
      case (state_q)
         S_EVEN: buf_wr = in_valid;
         S_ODD: begin
            in_ready = !out_valid || out_ready;
            odd_acc  = in_valid && (!out_valid || out_ready);
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < HALF; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] a, b, p, m;
      assign a = in_data[2*i*DATA_WIDTH +: DATA_WIDTH];
      assign b = in_data[(2*i+1)*DATA_WIDTH +: DATA_WIDTH];
      assign h[i*DATA_WIDTH +: DATA_WIDTH] = gt(a, b) ? a : b;
      assign p = buf_rd[i*DATA_WIDTH +: DATA_WIDTH];
      assign m = h[i*DATA_WIDTH +: DATA_WIDTH];
      assign pooled[i*DATA_WIDTH +: DATA_WIDTH] = gt(p, m) ? p : m;
   end

   pool_line_buf #(
      .DEPTH (BEATS),
      .WIDTH (OW),
      .AW    (BEAT_W)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (buf_wr),
      .addr    (beat_cnt),
      .wr_data (h),
      .rd_data (buf_rd)
   );

   // Output register. A new odd beat and a drain on the same edge keep
   // out_valid high with the new data, so there is no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= out_valid && out_ready && out_last;
         if (odd_acc) begin
            out_valid <= 1'b1;
            out_data  <= pooled;
            out_last  <= beat_end && (row_cnt == ROW_W'(LAST_ODD_ROW)) && ch_end;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream across four configurations:
//   dut_b  : LANES=4 W_IN=4 H_IN=2  C=1 unsigned (basic, signedness)
//   dut_bs : same geometry, signed
//   dut_o  : LANES=4 W_IN=8 H_IN=3  C=2 unsigned (odd height, stalls, reset)
//   dut_f  : LANES=8 W_IN=56 H_IN=56 C=4 signed (full-rate streaming)
module tb_max_pool_stream;
   import cnn_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- basic pair ----------------
   logic [31:0] b_in;
   logic        b_valid, b_oready;
   logic        b_ready, b_ov, b_last, b_done;
   logic        bs_ready, bs_ov, bs_last, bs_done;
   logic [15:0] b_out, bs_out;
   pool_state_e b_st, bs_st;

   max_pool_stream #(.DATA_WIDTH(8), .LANES(4), .W_IN(4), .H_IN(2), .C(1), .SIGNED(0)) dut_b (
      .clk(clk), .rst(rst), .in_data(b_in), .in_valid(b_valid), .in_ready(b_ready),
      .out_data(b_out), .out_valid(b_ov), .out_ready(b_oready), .out_last(b_last),
      .frame_done(b_done), .state(b_st));

   max_pool_stream #(.DATA_WIDTH(8), .LANES(4), .W_IN(4), .H_IN(2), .C(1), .SIGNED(1)) dut_bs (
      .clk(clk), .rst(rst), .in_data(b_in), .in_valid(b_valid), .in_ready(bs_ready),
      .out_data(bs_out), .out_valid(bs_ov), .out_ready(b_oready), .out_last(bs_last),
      .frame_done(bs_done), .state(bs_st));

   // ---------------- odd-height ----------------
   logic [31:0] o_in;
   logic        o_valid, o_oready, o_ready, o_ov, o_last, o_done;
   logic [15:0] o_out;
   pool_state_e o_st;

   max_pool_stream #(.DATA_WIDTH(8), .LANES(4), .W_IN(8), .H_IN(3), .C(2), .SIGNED(0)) dut_o (
      .clk(clk), .rst(rst), .in_data(o_in), .in_valid(o_valid), .in_ready(o_ready),
      .out_data(o_out), .out_valid(o_ov), .out_ready(o_oready), .out_last(o_last),
      .frame_done(o_done), .state(o_st));

   // ---------------- full-size ----------------
   logic [63:0] f_in;
   logic        f_valid, f_oready, f_ready, f_ov, f_last, f_done;
   logic [31:0] f_out;
   pool_state_e f_st;

   max_pool_stream #(.DATA_WIDTH(8), .LANES(8), .W_IN(56), .H_IN(56), .C(4), .SIGNED(1)) dut_f (
      .clk(clk), .rst(rst), .in_data(f_in), .in_valid(f_valid), .in_ready(f_ready),
      .out_data(f_out), .out_valid(f_ov), .out_ready(f_oready), .out_last(f_last),
      .frame_done(f_done), .state(f_st));

   // ---------------- reference model ----------------
   function automatic logic [7:0] umax(input logic [7:0] x, input logic [7:0] y);
      return (x > y) ? x : y;
   endfunction

   function automatic logic [7:0] smax(input logic [7:0] x, input logic [7:0] y);
      return ($signed(x) > $signed(y)) ? x : y;
   endfunction

   function automatic logic [7:0] o_pix(input int ch, input int row, input int col);
      return 8'(ch*37 + row*53 + col*29 + col*col*3 + 3);
   endfunction

   function automatic logic [31:0] o_beat(input int ch, input int row, input int b);
      logic [31:0] d;
      for (int l = 0; l < 4; l++) d[l*8 +: 8] = o_pix(ch, row, b*4 + l);
      return d;
   endfunction

   // {last, data} of the pooled beat from odd row r, beat b
   function automatic logic [16:0] o_exp(input int ch, input int r, input int b);
      logic [16:0] e;
      logic [7:0] up, dn;
      int c;
      e = '0;
      for (int i = 0; i < 2; i++) begin
         c  = b*4 + 2*i;
         up = umax(o_pix(ch, r-1, c), o_pix(ch, r-1, c+1));
         dn = umax(o_pix(ch, r, c), o_pix(ch, r, c+1));
         e[i*8 +: 8] = umax(up, dn);
      end
      e[16] = (ch == 1) && (b == 1);
      return e;
   endfunction

   function automatic logic [7:0] f_pix(input int fr, input int ch, input int row, input int col);
      return 8'(fr*71 + ch*29 + row*13 + col*7 + row*col);
   endfunction

   function automatic logic [63:0] f_beat(input int idx);
      logic [63:0] d;
      int fr, ch, row, b, rem;
      fr  = idx / 1568;
      rem = idx % 1568;
      ch  = rem / 392;
      rem = rem % 392;
      row = rem / 7;
      b   = rem % 7;
      for (int l = 0; l < 8; l++) d[l*8 +: 8] = f_pix(fr, ch, row, b*8 + l);
      return d;
   endfunction

   function automatic logic [32:0] f_exp(input int fr, input int ch, input int r, input int b);
      logic [32:0] e;
      logic [7:0] up, dn;
      int c;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         c  = b*8 + 2*i;
         up = smax(f_pix(fr, ch, r-1, c), f_pix(fr, ch, r-1, c+1));
         dn = smax(f_pix(fr, ch, r, c), f_pix(fr, ch, r, c+1));
         e[i*8 +: 8] = smax(up, dn);
      end
      e[32] = (ch == 3) && (r == 55) && (b == 6);
      return e;
   endfunction

   // ---------------- scoreboards ----------------
   logic [16:0] o_q[$];
   logic [32:0] f_q[$];
   logic [16:0] o_e;
   logic [32:0] f_e;
   int o_beats, o_lasts, o_dones;
   int f_beats, f_lasts, f_dones, f_stall;

   always @(negedge clk) begin
      if (!rst && o_ov && o_oready) begin
         o_beats++;
         if (o_last) o_lasts++;
         n_checks++;
         if (o_q.size() == 0) begin
            n_fail++;
            $display("FAIL o_unexpected: got last=%b data=%h, required no beat", o_last, o_out);
         end else begin
            o_e = o_q.pop_front();
            if ({o_last, o_out} !== o_e) begin
               n_fail++;
               $display("FAIL o_beat: got last=%b data=%h, required last=%b data=%h",
                        o_last, o_out, o_e[16], o_e[15:0]);
            end
         end
      end
      if (!rst && o_done) o_dones++;
   end

   always @(negedge clk) begin
      if (!rst && f_ov && f_oready) begin
         f_beats++;
         if (f_last) f_lasts++;
         n_checks++;
         if (f_q.size() == 0) begin
            n_fail++;
            $display("FAIL f_unexpected: got last=%b data=%h, required no beat", f_last, f_out);
         end else begin
            f_e = f_q.pop_front();
            if ({f_last, f_out} !== f_e) begin
               n_fail++;
               $display("FAIL f_beat #%0d: got last=%b data=%h, required last=%b data=%h",
                        f_beats, f_last, f_out, f_e[32], f_e[31:0]);
            end
         end
      end
      if (!rst && f_done) f_dones++;
   end

   // ---------------- drivers ----------------
   task automatic o_send(input logic [31:0] d);
      int t;
      t = 0;
      o_in    = d;
      o_valid = 1'b1;
      @(negedge clk);
      while (!o_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!o_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL o_send_timeout: got in_ready=0 for %0d cycles, required 1", t);
      end
      @(posedge clk);
      #1;
      o_valid = 1'b0;
   endtask

   task automatic o_frame();
      for (int ch = 0; ch < 2; ch++)
         for (int r = 0; r < 3; r++)
            for (int b = 0; b < 2; b++) begin
               if (r == 1) o_q.push_back(o_exp(ch, 1, b));
               o_send(o_beat(ch, r, b));
            end
   endtask

   task automatic o_clear_counts();
      o_beats = 0;
      o_lasts = 0;
      o_dones = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      b_in = '0; b_valid = 1'b0; b_oready = 1'b1;
      o_in = '0; o_valid = 1'b0; o_oready = 1'b1;
      f_in = '0; f_valid = 1'b0; f_oready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b_ov, b_last, b_done, b_ready} !== 4'b0001 || b_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_b: got v/l/d/r=%b data=%h, required 0001 data=0000",
                  {b_ov, b_last, b_done, b_ready}, b_out);
      end
      n_checks++;
      if ({bs_ov, bs_last, bs_done, bs_ready} !== 4'b0001 || bs_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_bs: got v/l/d/r=%b data=%h, required 0001 data=0000",
                  {bs_ov, bs_last, bs_done, bs_ready}, bs_out);
      end
      n_checks++;
      if ({o_ov, o_last, o_done, o_ready} !== 4'b0001 || o_out !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_o: got v/l/d/r=%b data=%h, required 0001 data=0000",
                  {o_ov, o_last, o_done, o_ready}, o_out);
      end
      n_checks++;
      if ({f_ov, f_last, f_done, f_ready} !== 4'b0001 || f_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_f: got v/l/d/r=%b data=%h, required 0001 data=0",
                  {f_ov, f_last, f_done, f_ready}, f_out);
      end
      n_checks++;
      if (b_st !== S_EVEN || bs_st !== S_EVEN || o_st !== S_EVEN || f_st !== S_EVEN) begin
         n_fail++;
         $display("FAIL reset_state: got %0d %0d %0d %0d, required all S_EVEN",
                  b_st, bs_st, o_st, f_st);
      end
   endtask

   // row0 {1,5,3,2}, row1 {4,0,9,7} -> {5,9}
   task automatic test_basic();
      @(posedge clk);
      #1 b_in = {8'd2, 8'd3, 8'd5, 8'd1}; b_valid = 1'b1;
      @(posedge clk);
      #1 b_in = {8'd7, 8'd9, 8'd0, 8'd4};
      @(posedge clk);
      #1 b_valid = 1'b0;
      n_checks++;
      if ({b_ov, b_last, b_done} !== 3'b110 || b_out !== 16'h0905) begin
         n_fail++;
         $display("FAIL basic_out: got v/l/d=%b data=%h, required 110 data=0905",
                  {b_ov, b_last, b_done}, b_out);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({b_ov, b_done} !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_done: got v/d=%b, required 01", {b_ov, b_done});
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (b_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got %b, required 0", b_done);
      end
   endtask

   // row0 {-3,-8,-3,2}, row1 {-5,-1,1,0}
   //   signed   -> {-1, 2}      = 16'h02FF
   //   unsigned -> {0xFF, 0xFD} = 16'hFDFF
   task automatic test_signed();
      @(posedge clk);
      #1 b_in = {8'h02, 8'hFD, 8'hF8, 8'hFD}; b_valid = 1'b1;
      @(posedge clk);
      #1 b_in = {8'h00, 8'h01, 8'hFF, 8'hFB};
      @(posedge clk);
      #1 b_valid = 1'b0;
      n_checks++;
      if ({bs_ov, bs_last} !== 2'b11 || bs_out !== 16'h02FF) begin
         n_fail++;
         $display("FAIL signed_out: got v/l=%b data=%h, required 11 data=02ff", {bs_ov, bs_last}, bs_out);
      end
      n_checks++;
      if ({b_ov, b_last} !== 2'b11 || b_out !== 16'hFDFF) begin
         n_fail++;
         $display("FAIL unsigned_out: got v/l=%b data=%h, required 11 data=fdff", {b_ov, b_last}, b_out);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic o_check_frames(input string tag, input int frames);
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (o_beats !== 4*frames || o_lasts !== frames || o_dones !== frames || o_q.size() !== 0) begin
         n_fail++;
         $display("FAIL %s: got beats=%0d lasts=%0d dones=%0d left=%0d, required %0d %0d %0d 0",
                  tag, o_beats, o_lasts, o_dones, o_q.size(), 4*frames, frames, frames);
      end
   endtask

   task automatic test_odd_height();
      o_oready = 1'b1;
      o_clear_counts();
      o_frame();
      o_check_frames("odd_height", 1);
   endtask

   task automatic test_back_to_back();
      o_oready = 1'b1;
      o_clear_counts();
      o_frame();
      o_frame();
      o_check_frames("back_to_back", 2);
   endtask

   task automatic test_backpressure();
      logic [16:0] held;
      o_clear_counts();
      o_oready = 1'b0;
      o_send(o_beat(0, 0, 0));
      o_send(o_beat(0, 0, 1));
      o_q.push_back(o_exp(0, 1, 0));
      o_send(o_beat(0, 1, 0));
      held    = o_exp(0, 1, 0);
      o_in    = o_beat(0, 1, 1);
      o_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (o_ready !== 1'b0 || o_ov !== 1'b1 || {o_last, o_out} !== held) begin
            n_fail++;
            $display("FAIL stall_%0d: got ready=%b valid=%b last=%b data=%h, required 0 1 %b %h",
                     k, o_ready, o_ov, o_last, o_out, held[16], held[15:0]);
         end
         @(posedge clk);
         #1;
      end
      o_oready = 1'b1;
      o_q.push_back(o_exp(0, 1, 1));
      o_send(o_beat(0, 1, 1));
      for (int ch = 0; ch < 2; ch++)
         for (int r = 0; r < 3; r++)
            for (int b = 0; b < 2; b++) begin
               if (ch == 0 && r < 2) continue;
               if (r == 1) o_q.push_back(o_exp(ch, 1, b));
               o_send(o_beat(ch, r, b));
            end
      o_check_frames("backpressure", 1);
   endtask

   task automatic test_reset_mid();
      o_oready = 1'b0;
      o_send(o_beat(0, 0, 0));
      o_send(o_beat(0, 0, 1));
      o_send(o_beat(0, 1, 0));
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (o_ov !== 1'b0 || o_last !== 1'b0 || o_out !== 16'h0 || o_st !== S_EVEN) begin
         n_fail++;
         $display("FAIL reset_async: got valid=%b last=%b data=%h state=%0d, required 0 0 0000 S_EVEN",
                  o_ov, o_last, o_out, o_st);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      o_oready = 1'b1;
      o_clear_counts();
      o_frame();
      o_check_frames("reset_mid_frame", 1);
   endtask

   task automatic test_full_throughput();
      int idx, cyc;
      logic acc;
      f_beats = 0; f_lasts = 0; f_dones = 0; f_stall = 0;
      for (int fr = 0; fr < 2; fr++)
         for (int ch = 0; ch < 4; ch++)
            for (int r = 1; r < 56; r += 2)
               for (int b = 0; b < 7; b++) f_q.push_back(f_exp(fr, ch, r, b));
      f_oready = 1'b1;
      idx      = 0;
      cyc      = 0;
      f_in     = f_beat(0);
      f_valid  = 1'b1;
      while (idx < 3136 && cyc < 6000) begin
         @(negedge clk);
         if (!f_ready) f_stall++;
         acc = f_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 3136) f_in = f_beat(idx);
         end
      end
      f_valid = 1'b0;
      n_checks++;
      if (idx != 3136) begin
         n_fail++;
         $display("FAIL full_timeout: got %0d beats accepted, required 3136", idx);
      end
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (f_stall !== 0) begin
         n_fail++;
         $display("FAIL full_in_ready: got %0d stall cycles, required 0", f_stall);
      end
      n_checks++;
      if (f_beats !== 1568 || f_lasts !== 2 || f_dones !== 2 || f_q.size() !== 0) begin
         n_fail++;
         $display("FAIL full_counts: got beats=%0d lasts=%0d dones=%0d left=%0d, required 1568 2 2 0",
                  f_beats, f_lasts, f_dones, f_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_odd_height();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_full_throughput();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
